score_tally: RTL and testbench
==============================

SCORE_TALLY -- requirements
Module: score_tally

Interface
REQ-001 Parameter X_MAX, default 160: number of valid x columns scanned (x = 0..X_MAX-1).
REQ-002 Parameter Y_MAX, default 120: number of valid y rows scanned (y = 0..Y_MAX-1).
REQ-003 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 running  input  1  game-active flag from the timer datapath; a 1->0 transition starts a tally.
REQ-006 ram_address  output  15  ownership RAM read address, {x[7:0], y[6:0]}.
REQ-007 ram_q  input  3  ownership RAM read data; valid exactly one CLOCK_50 cycle after ram_address is presented.
REQ-008 p1_count, p2_count, p3_count, p4_count  output  15 each  pixel counts owned by players 1-4.
REQ-009 winner  output  2  index of the winning player (0 = P1 ... 3 = P4).
REQ-010 busy  output  1  high while a tally is in progress.
REQ-011 done  output  1  high when counts and winner are final.

Function
REQ-012 Colour-to-owner map: 3'b001 = P1, 3'b010 = P2, 3'b100 = P3, 3'b110 = P4; any other value counts for nobody.
REQ-013 running is registered once; start = registered running high and current running low, evaluated every cycle.
REQ-014 States: IDLE, SCAN, DRAIN, COMPARE, DONE.
REQ-015 IDLE: busy=0; on start -> SCAN, clear all four counts, clear done, set x=0, y=0.
REQ-016 SCAN: each cycle present {x,y} on ram_address; y increments first, wraps Y_MAX-1 -> 0 with x+1; addresses with y >= Y_MAX or x >= X_MAX are never issued.
REQ-017 SCAN: issuing address (X_MAX-1, Y_MAX-1) -> DRAIN next cycle.
REQ-018 Accumulation pipeline: a valid-tag register follows each issued address; the ram_q arriving one cycle later increments exactly the matching count by 1; DRAIN exists to capture the final sample, then -> COMPARE.
REQ-019 Every issued address is sampled exactly once; a full scan reads X_MAX*Y_MAX = 19200 locations and takes 19200 SCAN cycles + 1 DRAIN cycle.
REQ-020 Counts are 15-bit unsigned; the maximum value 19200 fits, so no saturation logic is required.
REQ-021 COMPARE: one cycle; winner = index of the largest count; ties resolve to the lowest index (P1 over P2 over P3 over P4); all counts zero -> winner=0.
REQ-022 COMPARE -> DONE; DONE: done=1, busy=0; counts and winner hold until the next start or reset.
REQ-023 busy=1 in SCAN, DRAIN and COMPARE only.
REQ-024 A start occurring in SCAN, DRAIN or COMPARE is ignored; the current tally completes unchanged.
REQ-025 A start occurring in DONE -> SCAN with counts cleared and done=0 on the next cycle.
REQ-026 In IDLE and DONE, ram_address holds 15'd0.
REQ-027 Latency: done rises exactly 19202 cycles after the cycle in which start is detected (default parameters).

Reset
REQ-028 reset=1 at a rising edge forces IDLE; all counts = 0, winner = 0, busy = 0, done = 0, ram_address = 0, registered running = 0, pipeline valid tag = 0.
REQ-029 reset has priority over start and over any in-progress scan; a scan interrupted by reset is abandoned and requires a new start.
REQ-030 After reset, a running input that is already low produces no start until running is seen high and then low.

Verification
REQ-031 RAM model all 3'b001, running 1->0 -> p1_count=19200, other counts 0, winner=0, done high 19202 cycles after start.
REQ-032 RAM rows x<40 = 001, 40..79 = 010, 80..119 = 100, 120..159 = 110 -> each count 4800, winner=0 (tie to lowest index).
REQ-033 RAM all 3'b000 except 5 pixels = 110 and 3 pixels = 100, including corners (0,0) and (159,119) = 110 -> p4_count=5, p3_count=3, winner=3.
REQ-034 Address monitor: over one scan no address with y>=120 or x>=160 is issued; every valid address is issued exactly once, in y-fastest order.
REQ-035 reset asserted at cycle 5000 of a scan -> next cycle all outputs zero, state IDLE; a later start produces correct full counts.
REQ-036 Second running 1->0 pulse mid-scan -> ignored, results identical to single-start run; a start after done -> counts cleared, fresh tally completes.

Source files
------------

// File: rtl/score_tally.sv
// End-of-game scorer: walks the ownership RAM once, counts pixels per player and
// reports the player holding the most territory.
`timescale 1ns / 1ps

module score_tally #(
  parameter int X_MAX = 160,
  parameter int Y_MAX = 120
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        running,
  output logic [14:0] ram_address,
  input  logic [2:0]  ram_q,
  output logic [14:0] p1_count,
  output logic [14:0] p2_count,
  output logic [14:0] p3_count,
  output logic [14:0] p4_count,
  output logic [1:0]  winner,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, COMPARE, DONE} state_t;

  localparam logic [7:0] X_LAST = 8'(X_MAX - 1);
  localparam logic [6:0] Y_LAST = 7'(Y_MAX - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic             r_running;
  logic             r_valid;
  logic [7:0]       r_x;
  logic [6:0]       r_y;
  logic [3:0][14:0] r_count;
  logic [1:0]       r_winner;

  logic             w_start;
  logic             w_lastAddr;
  logic             w_hit;
  logic [1:0]       w_owner;
  logic [1:0]       w_bestIdx;
  logic [14:0]      w_bestVal;

  assign w_start    = r_running & ~running;
  assign w_lastAddr = (r_x == X_LAST) && (r_y == Y_LAST);

  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    ram_address = '0;
    case (r_state)
      IDLE: begin
        if (w_start) w_nextState = SCAN;
      end
      SCAN: begin
        busy        = 1'b1;
        ram_address = {r_x, r_y};
        if (w_lastAddr) w_nextState = DRAIN;
      end
      DRAIN: begin
        busy        = 1'b1;
        w_nextState = COMPARE;
      end
      COMPARE: begin
        busy        = 1'b1;
        w_nextState = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (w_start) w_nextState = SCAN;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Colours that do not belong to a player simply never hit a counter.
  always_comb begin
    w_hit   = 1'b0;
    w_owner = 2'd0;
    case (ram_q)
      3'b001: begin w_hit = 1'b1; w_owner = 2'd0; end
      3'b010: begin w_hit = 1'b1; w_owner = 2'd1; end
      3'b100: begin w_hit = 1'b1; w_owner = 2'd2; end
      3'b110: begin w_hit = 1'b1; w_owner = 2'd3; end
      default: begin w_hit = 1'b0; w_owner = 2'd0; end
    endcase
  end

  // Strictly-greater replacement keeps the lowest index on ties.
  always_comb begin
    w_bestIdx = 2'd0;
    w_bestVal = r_count[0];
    for (int i = 1; i < 4; i++) begin
      if (r_count[i] > w_bestVal) begin
        w_bestIdx = 2'(i);
        w_bestVal = r_count[i];
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_valid   <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_count   <= '0;
      r_winner  <= '0;
    end else begin
      r_state   <= w_nextState;
      r_running <= running;
      r_valid   <= (r_state == SCAN);

      if ((r_state == IDLE || r_state == DONE) && w_start) begin
        r_x      <= '0;
        r_y      <= '0;
        r_count  <= '0;
        r_winner <= '0;
      end else if (r_state == SCAN) begin
        if (r_y == Y_LAST) begin
          r_y <= '0;
          r_x <= r_x + 8'd1;
        end else begin
          r_y <= r_y + 7'd1;
        end
      end

      // RAM data lags its address by one cycle; the valid tag lines them up.
      if (r_valid && w_hit) begin
        r_count[w_owner] <= r_count[w_owner] + 15'd1;
      end

      if (r_state == COMPARE) begin
        r_winner <= w_bestIdx;
      end
    end
  end

  assign p1_count = r_count[0];
  assign p2_count = r_count[1];
  assign p3_count = r_count[2];
  assign p4_count = r_count[3];
  assign winner   = r_winner;

endmodule

// File: tb/tb_score_tally.sv
// Scoreboard bench for score_tally: a behavioural model predicts each tally, a
// monitor compares the results whenever done rises.
`timescale 1ns / 1ps

module tb_score_tally;

  localparam int XN = 160;
  localparam int YN = 120;
  localparam int SCAN_LEN = XN * YN;
  localparam int LATENCY = 19202;

  typedef struct packed {
    int c0;
    int c1;
    int c2;
    int c3;
    int win;
    int startEdge;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        running;
  logic [2:0]  ramQ;
  logic [14:0] ram_address;
  logic [14:0] p1_count;
  logic [14:0] p2_count;
  logic [14:0] p3_count;
  logic [14:0] p4_count;
  logic [1:0]  winner;
  logic        busy;
  logic        done;

  logic [2:0]  mem [XN][YN];
  exp_t        expQ[$];
  exp_t        monExp;
  int          errors = 0;
  int          checks = 0;
  int          cycle = 0;
  logic        prevDone = 1'b0;

  score_tally #(.X_MAX(XN), .Y_MAX(YN)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .running    (running),
    .ram_address(ram_address),
    .ram_q      (ramQ),
    .p1_count   (p1_count),
    .p2_count   (p2_count),
    .p3_count   (p3_count),
    .p4_count   (p4_count),
    .winner     (winner),
    .busy       (busy),
    .done       (done)
  );

  // Free-running clock and a posedge counter used to measure latency.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle++;

  // Synchronous-read ownership RAM: data appears one cycle after the address.
  always @(posedge clk) begin
    if (int'(ram_address[14:7]) < XN && int'(ram_address[6:0]) < YN)
      ramQ <= mem[int'(ram_address[14:7])][int'(ram_address[6:0])];
    else
      ramQ <= 3'b000;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference tally: count colours per player, then pick the first maximum.
  function automatic exp_t modelTally();
    exp_t e;
    int   cnt [4];
    int   best;
    for (int p = 0; p < 4; p++) cnt[p] = 0;
    for (int x = 0; x < XN; x++) begin
      for (int y = 0; y < YN; y++) begin
        case (mem[x][y])
          3'b001: cnt[0]++;
          3'b010: cnt[1]++;
          3'b100: cnt[2]++;
          3'b110: cnt[3]++;
          default: ;
        endcase
      end
    end
    best = 0;
    for (int p = 1; p < 4; p++) if (cnt[p] > cnt[best]) best = p;
    e.c0 = cnt[0];
    e.c1 = cnt[1];
    e.c2 = cnt[2];
    e.c3 = cnt[3];
    e.win = best;
    e.startEdge = 0;
    return e;
  endfunction

  task automatic checkZero(input string tag);
    checkOutput({tag, "_p1"}, int'(p1_count), 0);
    checkOutput({tag, "_p2"}, int'(p2_count), 0);
    checkOutput({tag, "_p3"}, int'(p3_count), 0);
    checkOutput({tag, "_p4"}, int'(p4_count), 0);
    checkOutput({tag, "_winner"}, int'(winner), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_addr"}, int'(ram_address), 0);
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (!done && n < SCAN_LEN + 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) checkOutput("doneTimeout", 0, 1);
  endtask

  // Runs one tally; pulseAt >= 0 re-pulses running mid-scan, abortAt >= 0 resets mid-scan.
  task automatic applyStimulus(input int pulseAt, input int abortAt);
    exp_t       e;
    int         bad;
    int         limit;
    logic [7:0] ex;
    logic [6:0] ey;
    e = modelTally();
    running = 1'b1;
    repeat (2) @(negedge clk);
    running = 1'b0;
    e.startEdge = cycle + 1;
    if (abortAt < 0) expQ.push_back(e);
    bad = 0;
    limit = (abortAt < 0) ? SCAN_LEN : abortAt;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checkOutput("busyAtStart", int'(busy), 1);
        checkOutput("doneClearedAtStart", int'(done), 0);
      end
      ex = 8'(k / YN);
      ey = 7'(k % YN);
      if (ram_address !== {ex, ey}) bad++;
      if (pulseAt >= 0 && k == pulseAt) running = 1'b1;
      if (pulseAt >= 0 && k == pulseAt + 2) running = 1'b0;
    end
    checkOutput("addrSequenceErrors", bad, 0);
    if (abortAt >= 0) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkZero("abort");
    end else begin
      waitDone();
    end
  endtask

  task automatic placeUnique(input logic [2:0] val);
    int x;
    int y;
    do begin
      x = $urandom_range(XN - 1, 0);
      y = $urandom_range(YN - 1, 0);
    end while (mem[x][y] != 3'b000);
    mem[x][y] = val;
  endtask

  // Monitor: every rising done pops one prediction and compares the results.
  always @(negedge clk) begin
    if (done && !prevDone) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedDone", 1, 0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("p1_count", int'(p1_count), monExp.c0);
        checkOutput("p2_count", int'(p2_count), monExp.c1);
        checkOutput("p3_count", int'(p3_count), monExp.c2);
        checkOutput("p4_count", int'(p4_count), monExp.c3);
        checkOutput("winner", int'(winner), monExp.win);
        checkOutput("doneLatency", cycle - monExp.startEdge, LATENCY);
        checkOutput("busyInDone", int'(busy), 0);
        checkOutput("addrInDone", int'(ram_address), 0);
      end
    end
    prevDone = done;
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    running = 1'b0;
    for (int x = 0; x < XN; x++)
      for (int y = 0; y < YN; y++) mem[x][y] = 3'b000;
    repeat (3) @(negedge clk);
    checkZero("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("noStartWhileLow_busy", int'(busy), 0);
    checkOutput("noStartWhileLow_done", int'(done), 0);

    $display("[TB] all pixels owned by P1");
    for (int x = 0; x < XN; x++)
      for (int y = 0; y < YN; y++) mem[x][y] = 3'b001;
    applyStimulus(-1, -1);

    $display("[TB] four equal stripes, extra running pulse mid-scan");
    for (int x = 0; x < XN; x++)
      for (int y = 0; y < YN; y++)
        mem[x][y] = (x < 40) ? 3'b001 : (x < 80) ? 3'b010 : (x < 120) ? 3'b100 : 3'b110;
    applyStimulus(7000, -1);

    $display("[TB] sparse pixels including both corners");
    for (int x = 0; x < XN; x++)
      for (int y = 0; y < YN; y++) mem[x][y] = 3'b000;
    mem[0][0] = 3'b110;
    mem[XN-1][YN-1] = 3'b110;
    repeat (3) placeUnique(3'b110);
    repeat (3) placeUnique(3'b100);
    applyStimulus(-1, -1);

    $display("[TB] random colours, reset mid-scan then a fresh tally");
    for (int x = 0; x < XN; x++)
      for (int y = 0; y < YN; y++) mem[x][y] = 3'($urandom_range(7, 0));
    applyStimulus(-1, 5000);
    repeat (3) @(negedge clk);
    checkOutput("idleAfterAbort_busy", int'(busy), 0);
    applyStimulus(-1, -1);

    repeat (3) @(negedge clk);
    checkOutput("pendingPredictions", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
